// File: rtl/muldiv_sequencer_if.sv
// Handshake and operand/result bundle between the execute stage and the
// iterative RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int W_SIZE = 32
);
  logic              start;
  logic [2:0]        op;
  logic [W_SIZE-1:0] a;
  logic [W_SIZE-1:0] b;
  logic              kill;
  logic              busy;
  logic              stall;
  logic              valid;
  logic [W_SIZE-1:0] result;

  modport master (output start, op, a, b, kill, input busy, stall, valid, result);
  modport slave  (input start, op, a, b, kill, output busy, stall, valid, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand multiplies, divide-by-zero and signed overflow in one cycle.
module muldiv_sequencer #(
  parameter int W_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  muldiv_sequencer_if.slave    bus
);
  localparam int CNT_W = $clog2(W_SIZE + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [W_SIZE-1:0] result_q;

  logic [2:0]        op_q;
  logic              neg_a_q, neg_b_q, div0_q, ovf_q, zero_q;
  logic [W_SIZE-1:0] mag_a_q, mag_b_q, acc_hi_q, acc_lo_q;

  logic              sgn_a, sgn_b, neg_a, neg_b, div0, ovf, mulz, early, accept;
  logic [W_SIZE-1:0] mag_a, mag_b, acc_hi_nxt, acc_lo_nxt, fixed;
  logic [W_SIZE:0]   mul_sum, div_shift, div_diff;

  // Undo magnitude arithmetic and apply RV32M corner-case results.
  function automatic logic [W_SIZE-1:0] fix_result(
    input logic [2:0]        op,
    input logic              na, nb, dz, ov, zr,
    input logic [W_SIZE-1:0] hi, lo, dividend
  );
    logic [2*W_SIZE-1:0] prod;
    logic [W_SIZE-1:0]   quo, rem;
    prod = {hi, lo};
    if (na ^ nb) prod = -prod;
    if (zr) prod = '0;
    quo = (na ^ nb) ? -lo : lo;
    rem = na ? -hi : hi;
    if (dz) begin
      quo = '1;
      rem = na ? -dividend : dividend;
    end
    if (ov) begin
      quo = {1'b1, {(W_SIZE-1){1'b0}}};
      rem = '0;
    end
    case (op)
      3'b000:                 fix_result = prod[W_SIZE-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod[2*W_SIZE-1:W_SIZE];
      3'b100, 3'b101:         fix_result = quo;
      default:                fix_result = rem;
    endcase
  endfunction

  always_comb begin
    sgn_a  = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
    sgn_b  = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
    neg_a  = sgn_a & bus.a[W_SIZE-1];
    neg_b  = sgn_b & bus.b[W_SIZE-1];
    mag_a  = neg_a ? -bus.a : bus.a;
    mag_b  = neg_b ? -bus.b : bus.b;
    div0   = bus.op[2] & (bus.b == '0);
    ovf    = bus.op[2] & ~bus.op[0] & (bus.a == {1'b1, {(W_SIZE-1){1'b0}}}) & (bus.b == '1);
    mulz   = ~bus.op[2] & ((bus.a == '0) | (bus.b == '0));
`ifdef MULDIV_EARLY_OUT_EN
    early  = div0 | ovf | mulz;
`else
    early  = 1'b0;
`endif
    accept = (state == IDLE) & bus.start & ~bus.kill;
  end

  // One iteration: multiply shifts the {sum, multiplier} pair right, divide shifts left.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[W_SIZE-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (op_q[2]) begin
      if (!div_diff[W_SIZE]) begin
        acc_hi_nxt = div_diff[W_SIZE-1:0];
        acc_lo_nxt = {acc_lo_q[W_SIZE-2:0], 1'b1};
      end else begin
        acc_hi_nxt = div_shift[W_SIZE-1:0];
        acc_lo_nxt = {acc_lo_q[W_SIZE-2:0], 1'b0};
      end
    end else begin
      acc_hi_nxt = mul_sum[W_SIZE:1];
      acc_lo_nxt = {mul_sum[0], acc_lo_q[W_SIZE-1:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early ? DONE : BUSY;
      BUSY:    if (cnt_q == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.kill) state_nxt = IDLE;

    fixed      = fix_result(op_q, neg_a_q, neg_b_q, div0_q, ovf_q, zero_q,
                            acc_hi_q, acc_lo_q, mag_a_q);
    bus.busy   = (state != IDLE);
    bus.stall  = accept | (state == BUSY);
    bus.valid  = (state == DONE) & ~bus.kill;
    bus.result = bus.valid ? fixed : result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt_q <= CNT_W'(W_SIZE);
      else if (state == BUSY)
        cnt_q <= cnt_q - CNT_W'(1);
      if (bus.valid)
        result_q <= fixed;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= bus.op;
      neg_a_q  <= neg_a;
      neg_b_q  <= neg_b;
      div0_q   <= div0;
      ovf_q    <= ovf;
      zero_q   <= mulz;
      mag_a_q  <= mag_a;
      mag_b_q  <= mag_b;
      acc_hi_q <= '0;
      acc_lo_q <= bus.op[2] ? mag_a : mag_b;
    end else if (state == BUSY) begin
      acc_hi_q <= acc_hi_nxt;
      acc_lo_q <= acc_lo_nxt;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (honours MULDIV_EARLY_OUT_EN).
module tb_muldiv_sequencer;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.W_SIZE(W)) bus ();
  muldiv_sequencer #(.W_SIZE(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] last_res;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp,
                        input bit early, input bit disturb);
    int n, stalls, lat;
    bit got;
    logic [W-1:0] res;
    lat = early ? 1 : W + 1;
    n = 0; got = 1'b0; res = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    #1;
    chk({tag, " stall@start"}, W'(bus.stall), 1);
    stalls = bus.stall ? 1 : 0;
    while (!got && n < 3 * W) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (disturb && n == 5) begin
        bus.start = 1'b1; bus.op = 3'b101; bus.a = '1; bus.b = 3;
      end
      #1;
      if (bus.valid) begin
        got = 1'b1;
        res = bus.result;
        chk({tag, " stall@valid"}, W'(bus.stall), 0);
      end else if (bus.stall) stalls++;
    end
    chk({tag, " valid seen"}, W'(got), 1);
    chk({tag, " latency"}, W'(n), W'(lat));
    chk({tag, " stall cycles"}, W'(stalls), W'(lat));
    chk({tag, " result"}, res, exp);
    if (disturb) begin
      bus.start = 1'b1; bus.op = 3'b100; bus.a = 1; bus.b = 1;
    end
    @(negedge clk);
    #1;
    chk({tag, " busy after"}, W'(bus.busy), 0);
    chk({tag, " valid after"}, W'(bus.valid), 0);
    chk({tag, " result held"}, bus.result, exp);
    bus.start = 1'b0;
    last_res = exp;
  endtask

  initial begin
    int k;
    bit saw_valid;
    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", W'(bus.busy), 0);
    chk("reset valid", W'(bus.valid), 0);
    chk("reset stall", W'(bus.stall), 0);
    chk("reset result", bus.result, 0);
    rst = 1'b0;

    run_op("MUL 7*-3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("MULH min*min",  3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
    run_op("MULHU",         3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
    run_op("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("DIV -7/2",      3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("REM -7%2",      3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("DIVU 100/7",    3'b101, 32'd100,        32'd7,         32'd14,        1'b0, 1'b0);
    run_op("REMU 100%7",    3'b111, 32'd100,        32'd7,         32'd2,         1'b0, 1'b0);
    run_op("DIV 5/0",       3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, EARLY, 1'b0);
    run_op("REM 5%0",       3'b110, 32'd5,          32'd0,         32'd5,         EARLY, 1'b0);
    run_op("DIV -20/0",     3'b100, 32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFFF, EARLY, 1'b0);
    run_op("REM -20%0",     3'b110, 32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFEC, EARLY, 1'b0);
    run_op("DIV ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, EARLY, 1'b0);
    run_op("REM ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         EARLY, 1'b0);
    run_op("MUL 0*5",       3'b000, 32'd0,          32'd5,         32'd0,         EARLY, 1'b0);
    run_op("MULH x*0",      3'b001, 32'h1234_5678,  32'd0,         32'd0,         EARLY, 1'b0);

    // kill at iteration 10 of a DIVU
    saw_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'd1000; bus.b = 32'd9;
    for (k = 1; k < 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.valid) saw_valid = 1'b1;
    end
    @(negedge clk);
    bus.kill = 1'b1;
    #1;
    chk("kill valid during", W'(bus.valid), 0);
    @(negedge clk);
    bus.kill = 1'b0;
    #1;
    chk("kill busy", W'(bus.busy), 0);
    chk("kill valid", W'(bus.valid), 0);
    chk("kill stall", W'(bus.stall), 0);
    chk("kill result kept", bus.result, last_res);
    chk("kill no early valid", W'(saw_valid), 0);
    run_op("DIVU after kill", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);

    run_op("MUL 6*5 disturbed", 3'b000, 32'd6, 32'd5, 32'd30, 1'b0, 1'b1);

    // kill together with start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd3;
    #1;
    chk("kill+start stall", W'(bus.stall), 0);
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    #1;
    chk("kill+start busy", W'(bus.busy), 0);

    // reset mid-BUSY
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd9; bus.b = 32'd9;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst busy", W'(bus.busy), 0);
    chk("rst valid", W'(bus.valid), 0);
    chk("rst stall", W'(bus.stall), 0);
    chk("rst result", bus.result, 0);
    rst = 1'b0;
    run_op("MUL 2*3 after rst", 3'b000, 32'd2, 32'd3, 32'd6, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
